// File: rtl/bnn_seq_ctrl_pkg.sv
// Shared definitions for the sequential BNN inference controller: state
// encoding, prediction-width helper and default core latency.
package bnn_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Run counter is sized for the largest legal latency (1023).
  localparam int RUN_CNT_W = 10;

  function automatic int pred_w(input int class_cnt);
    return (class_cnt < 2) ? 1 : $clog2(class_cnt);
  endfunction

  // Hidden layer, output layer, plus two pipeline cycles in the core.
  function automatic int lat(input int hidden_cnt, input int class_cnt);
    return hidden_cnt + class_cnt + 2;
  endfunction

endpackage

// File: rtl/bnn_seq_ctrl.sv
// Sequencing controller for one ROM-weight BNN core: latches a feature vector,
// pulses the core reset, waits the fixed latency and captures the prediction.
module bnn_seq_ctrl
  import bnn_seq_ctrl_pkg::*;
#(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter int LATENCY    = lat(HIDDEN_CNT, CLASS_CNT),
  parameter int CNT_W      = 16,
  localparam int PRED_W    = pred_w(CLASS_CNT),
  localparam int FEAT_W    = FEAT_CNT * FEAT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_features,
  output logic              core_rst,
  output logic [FEAT_W-1:0] core_features,
  input  logic [PRED_W-1:0] core_prediction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PRED_W-1:0] out_prediction,
  output logic              busy,
  output logic [CNT_W-1:0]  infer_cnt
);

  localparam logic [RUN_CNT_W-1:0] RUN_LOAD = RUN_CNT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [RUN_CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic                  core_rst_q, core_rst_d;
  logic [FEAT_W-1:0]     feat_q, feat_d;
  logic [PRED_W-1:0]     pred_q, pred_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= '0;
      core_rst_q <= 1'b0;
      feat_q     <= '0;
      pred_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      core_rst_q <= core_rst_d;
      feat_q     <= feat_d;
      pred_q     <= pred_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    core_rst_d = 1'b0;
    feat_d     = feat_q;
    pred_d     = pred_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ST_LOAD: begin
        run_cnt_d = RUN_LOAD;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (run_cnt_q == '0) begin
          pred_d  = core_prediction;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_DONE;
        end else begin
          run_cnt_d = run_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // in_ready must not depend on in_valid, only on out_ready.
        if (out_ready) begin
          in_ready = 1'b1;
          accept   = in_valid;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      feat_d     = in_features;
      state_d    = ST_LOAD;
      core_rst_d = 1'b1;
    end
  end

  assign core_rst       = core_rst_q;
  assign core_features  = feat_q;
  assign out_valid      = (state_q == ST_DONE);
  assign out_prediction = pred_q;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign infer_cnt      = cnt_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Randomized scoreboard bench for bnn_seq_ctrl with a behavioural core model
// whose prediction only becomes valid after the full latency.
module tb_bnn_seq_ctrl;

  localparam int FEAT_CNT  = 12;
  localparam int FEAT_BITS = 4;
  localparam int FW        = FEAT_CNT * FEAT_BITS;
  localparam int LAT       = 48;
  localparam int CNT_W     = 2;
  localparam int PW        = 3;

  typedef struct {
    logic [FW-1:0] feat;
    int            pred;
    int            cnt;
    int            hs;
    int            due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [FW-1:0]   in_features = '0;
  logic            core_rst;
  logic [FW-1:0]   core_features;
  logic [PW-1:0]   core_prediction;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PW-1:0]   out_prediction;
  logic            busy;
  logic [CNT_W-1:0] infer_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   last_pred = 0;
  int   rdy_mode = 1;
  int   core_cyc = 0;
  bit   prev_valid = 1'b0;
  exp_t q[$];

  bnn_seq_ctrl #(
    .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .HIDDEN_CNT(40),
    .CLASS_CNT(6), .LATENCY(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .core_rst(core_rst), .core_features(core_features),
    .core_prediction(core_prediction), .out_valid(out_valid), .out_ready(out_ready),
    .out_prediction(out_prediction), .busy(busy), .infer_cnt(infer_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: answer is the feature vector mod 6, but only once LAT cycles
  // have elapsed since core reset release; before that it shows class 7.
  always @(posedge clk) begin
    if (core_rst) core_cyc <= 0;
    else if (core_cyc < 100000) core_cyc <= core_cyc + 1;
  end
  always_comb begin
    core_prediction = 3'd7;
    if (core_cyc >= LAT - 1) core_prediction = PW'(core_features % 6);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = ($urandom_range(0, 2) != 0);
        1: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_rst", core_rst, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_infer_cnt", infer_cnt, 0);
        chk("rst_out_pred", out_prediction, 0);
        chk("rst_core_feat", core_features, 0);
        prev_valid = 1'b0;
      end else begin
        bit has, exp_busy;
        has      = (q.size() > 0);
        exp_busy = has && (q[0].hs <= cyc) && !out_valid;
        chk("busy", busy, exp_busy);
        chk("core_rst", core_rst, has && (q[0].hs == cyc));
        chk("in_ready", in_ready, !exp_busy && (!out_valid || out_ready));
        if (has && (exp_busy || out_valid)) chk("core_features", core_features, q[0].feat);
        if (out_valid && !prev_valid) begin
          if (!has) chk("spurious_out_valid", 1, 0);
          else begin
            chk("out_valid_rise_cycle", cyc, q[0].due);
            chk("infer_cnt", infer_cnt, q[0].cnt);
          end
        end
        if (out_valid && has) chk("out_prediction", out_prediction, q[0].pred);
        else if (!out_valid) chk("held_prediction", out_prediction, last_pred);
        if (has && !out_valid && cyc == q[0].due) chk("out_valid_late", 0, 1);
        if (out_valid && out_ready && has) begin
          $display("OUT pred %0d infer_cnt %0d cycle %0d", out_prediction, infer_cnt, cyc);
          last_pred = q[0].pred;
          void'(q.pop_front());
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic push(input logic [FW-1:0] f);
    exp_t e;
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    e.feat = f;
    e.pred = int'(f % 6);
    e.cnt  = model_cnt;
    e.hs   = cyc + 1;
    e.due  = cyc + 2 + LAT;
    q.push_back(e);
    $display("IN  feat %0h expect pred %0d cnt %0d at cycle %0d", f, e.pred, e.cnt, e.due);
  endtask

  task automatic send(input logic [FW-1:0] f, input int gap, input bit keep);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; in_valid = 1'b0; end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_features = f;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (in_ready) begin push(f); ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!keep) begin @(posedge clk); #1; in_valid = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; in_valid = 1'b0; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    rdy_mode = 1;
    idle(1);
    while (q.size() > 0 && t < 5000) begin @(posedge clk); t++; end
    if (q.size() > 0) chk("drain_timeout", 0, 1);
    idle(2);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 2000) begin @(negedge clk); t++; end
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [FW-1:0] f;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Single inference expecting class 3
    rdy_mode = 1;
    send(48'h3, 1, 0);
    drain();

    // Backpressure with ignored in_valid pulses
    rdy_mode = 2;
    send(48'h5a5_1234_0008, 0, 0);
    wait_valid();
    repeat (20) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 1);
      in_features = {$urandom, $urandom};
    end
    @(posedge clk); #1; in_valid = 1'b0;
    drain();

    // Back-to-back with predictions 0..4
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      f = FW'(6 * (i + 7) + i);
      send(f, 0, 1);
    end
    drain();

    // Randomized traffic
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) begin
      f = {$urandom, $urandom};
      send(f, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset mid-RUN: no capture and no count for the discarded vector
    send(48'hbeef, 0, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    model_cnt = 0;
    last_pred = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    idle(70);
    send(48'h1, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
